// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a little-endian byte stream into IMEM words and
// holds the core in reset until the image is loaded (LOADER_CHECKSUM_EN adds a sum check).
module imem_boot_loader #(
    parameter int          MEM_NBYTE = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_rst_n,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        PAYLOAD,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t POST = CHK;
`else
    localparam state_t POST = DONE;
`endif

    localparam logic [31:0] MAX_WORDS = 32'(MEM_NBYTE / 4);

    state_t      state_q;
    state_t      state_d;
    logic        in_ready_q;
    logic        core_rst_q;
    logic [15:0] len_q;
    logic [15:0] word_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] pack_q;
    logic        accept;
    logic [15:0] len_n;
    logic        last_word;
    logic        rdy_d;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
    logic [7:0]  sum_fin;
    assign sum_fin = sum_q + in_data;
`endif

    assign accept    = in_valid & in_ready_q;
    assign len_n     = {in_data, len_q[7:0]};
    assign last_word = (word_cnt_q + 16'd1) == len_q;

    assign in_ready   = in_ready_q;
    assign core_rst_n = core_rst_q;
    assign busy       = (state_q != DONE) && (state_q != ERR);
    assign err        = (state_q == ERR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HDR0;
        else        state_q <= state_d;
    end

    // Next-state decode and ready for the coming cycle
    always_comb begin
        state_d = state_q;
        rdy_d   = 1'b0;
        unique case (state_q)
            HDR0: if (accept) state_d = HDR1;
            HDR1: begin
                if (accept) begin
                    if ({16'd0, len_n} > MAX_WORDS) state_d = ERR;
                    else if (len_n == 16'd0)        state_d = POST;
                    else                            state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept && byte_cnt_q == 2'd3 && last_word)
                    state_d = POST;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept)
                    state_d = (sum_fin == 8'd0) ? DONE : ERR;
            end
`endif
            DONE: state_d = DONE;
            ERR:  state_d = ERR;
            default: state_d = ERR;
        endcase
        rdy_d = (state_d != DONE) && (state_d != ERR);
    end

    // Handshake ready and core reset release, both registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b0;
            core_rst_q <= 1'b0;
        end else begin
            in_ready_q <= rdy_d;
            core_rst_q <= (state_q == DONE);
        end
    end

    // Header capture, byte packing and the one-cycle word write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= 16'd0;
            word_cnt_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            pack_q     <= 24'd0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= 32'd0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    HDR0: len_q[7:0]  <= in_data;
                    HDR1: len_q[15:8] <= in_data;
                    PAYLOAD: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        unique case (byte_cnt_q)
                            2'd0: pack_q[7:0]   <= in_data;
                            2'd1: pack_q[15:8]  <= in_data;
                            2'd2: pack_q[23:16] <= in_data;
                            default: begin
                                wr_en      <= 1'b1;
                                wr_data    <= {in_data, pack_q};
                                wr_addr    <= BASE_ADDR
                                            + {14'd0, word_cnt_q, 2'b00};
                                word_cnt_q <= word_cnt_q + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running mod-256 sum over header and payload bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'd0;
        end else if (accept && (state_q == HDR0 || state_q == HDR1
                                || state_q == PAYLOAD)) begin
            sum_q <= sum_fin;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader.
// Expected writes are queued as bytes are driven and checked on wr_en.
module tb_imem_boot_loader;

    localparam int          NBYTE = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_rst_n;
    logic        busy;
    logic        err;

    int tests;
    int fails;
    int nwr;

    logic [63:0] sb[$];
    logic [7:0]  stream[$];

    imem_boot_loader #(
        .MEM_NBYTE(NBYTE),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .core_rst_n(core_rst_n),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every IMEM write with the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            nwr++;
            if (sb.size() == 0) begin
                chk("unexpected_wr", wr_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e[63:32]);
                chk("wr_data", wr_data, e[31:0]);
            end
        end
    end

    function automatic logic [7:0] cks();
        logic [7:0] s;
        s = 8'd0;
        foreach (stream[i]) s = s + stream[i];
        return 8'd0 - s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int idle);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the stream; queue each complete payload word as its last byte goes out
    task automatic send_stream(input int idle);
        int len;
        logic [31:0] w;
        len = 0;
        w   = 32'd0;
        if (stream.size() >= 2) len = {stream[1], stream[0]};
        for (int i = 0; i < stream.size(); i++) begin
            if (i >= 2 && (i - 2) < 4 * len) begin
                int k;
                k = (i - 2) % 4;
                w[8*k +: 8] = stream[i];
                if (k == 3)
                    sb.push_back({BASE + 32'(4 * ((i - 2) / 4)), w});
            end
            send_byte(stream[i], (i == stream.size() - 1) ? 0 : idle);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_low_after_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_rise", 32'(in_ready), 32'd1);
    endtask

    // Just after the final accept: DONE entered, release follows one cycle later
    task automatic check_done(input string tag, input int exp_wr);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_core_rst_early"}, 32'(core_rst_n), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_nwr"}, 32'(nwr), 32'(exp_wr));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic load_main();
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00};
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        nwr      = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Back-to-back two-word image
        do_reset();
        nwr = 0;
        load_main();
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(cks());
`endif
        send_stream(0);
        check_done("b2b", 2);

        // Same image with in_valid pattern 1,0,0,1
        do_reset();
        nwr = 0;
        load_main();
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(cks());
`endif
        send_stream(2);
        check_done("gap", 2);

        // Oversized length
        do_reset();
        nwr = 0;
        stream = '{8'h01, 8'h01};
        send_stream(0);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("ovf_nwr", 32'(nwr), 32'd0);

        // Zero-length image
        do_reset();
        nwr = 0;
        stream = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(cks());
`endif
        send_stream(0);
        check_done("zero", 0);

        // Reset in the middle of the payload, then reload
        do_reset();
        nwr = 0;
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05};
        send_stream(0);
        rst_n = 1'b0;
        #1;
        chk("mid_wr_en", 32'(wr_en), 32'd0);
        chk("mid_wr_addr", wr_addr, BASE);
        chk("mid_wr_data", wr_data, 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_nwr", 32'(nwr), 32'd1);
        chk("mid_sb_empty", 32'(sb.size()), 32'd0);
        do_reset();
        nwr = 0;
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(cks());
`endif
        send_stream(0);
        check_done("reload", 1);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: words land but the core stays in reset
        do_reset();
        nwr = 0;
        load_main();
        stream.push_back(8'h00);
        send_stream(0);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bad_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("bad_nwr", 32'(nwr), 32'd2);
`endif

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
